// File: rtl/dma_xfer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_xfer_pkg
// Purpose  : Shared constants and helpers for the DMA transfer sequencer.
//            Holds the sequencer state encoding, the cache-line byte size
//            and a small address helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dma_xfer_pkg;

    // Bytes per cache line moved by one DMA beat.
    localparam int CL_BYTES = 64;

    // Sequencer state encoding.
    typedef logic [2:0] state_t;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ZERO  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    // Byte offset of cache line `lines` from a base address.
    function automatic logic [63:0] cl_byte_offset(input logic [31:0] lines);
        return 64'(lines) * 64'(CL_BYTES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_xfer_buf.sv
`default_nettype none
// ============================================================================
// Module   : dma_xfer_buf
// Purpose  : Synchronous show-ahead FIFO used as the elastic buffer between
//            the DMA read and write channels. The head entry is always
//            visible on data_o while the FIFO is not empty.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            flush_i       - synchronous flush (empties the FIFO)
//            push_i/data_i - write a new entry (ignored when full)
//            pop_i         - drop the head entry (ignored when empty)
//            data_o        - head entry
//            full_o/empty_o- occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module dma_xfer_buf #(
    parameter int DATA_WIDTH = 512,
    parameter int BUF_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int            PTR_W    = $clog2(BUF_DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W:0]        cnt_q;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked solely by cnt_q.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/dma_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dma_xfer_ctrl
// Purpose  : DMA transfer sequencer. On go, latches source/destination
//            address and line count, starts both DMA channels, streams lines
//            from the read channel through an elastic buffer into the write
//            channel, and raises a sticky done once every line has been
//            pushed and the write channel reports completion.
// Option   : DMA_XFER_XFORM_EN - adds xform_key (latched on go, XORed into
//            write data) and xform_active (high while busy).
// Ports    : clk, rst                   - clock, synchronous active-high reset
//            go, src_addr, dst_addr, size - transfer request from memory map
//            done, busy, lines_done       - status back to memory map
//            dma_rd_*/dma_empty           - read channel control and data
//            dma_wr_*/dma_full            - write channel control and data
// Revision : 1.0 - initial release
// ============================================================================
module dma_xfer_ctrl
    import dma_xfer_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 17,
    parameter int DATA_WIDTH = 512,
    parameter int BUF_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [SIZE_WIDTH-1:0] size,
    output logic                  done,
    output logic                  busy,
    output logic [SIZE_WIDTH-1:0] lines_done,
    output logic [ADDR_WIDTH-1:0] dma_rd_addr,
    output logic [ADDR_WIDTH-1:0] dma_wr_addr,
    output logic [SIZE_WIDTH-1:0] dma_rd_size,
    output logic [SIZE_WIDTH-1:0] dma_wr_size,
    output logic                  dma_rd_go,
    output logic                  dma_wr_go,
    input  logic                  dma_empty,
    input  logic [DATA_WIDTH-1:0] dma_rd_data,
    output logic                  dma_rd_en,
    input  logic                  dma_rd_done,
    input  logic                  dma_full,
    output logic [DATA_WIDTH-1:0] dma_wr_data,
    output logic                  dma_wr_en,
`ifdef DMA_XFER_XFORM_EN
    input  logic [DATA_WIDTH-1:0] xform_key,
    output logic                  xform_active,
`endif
    input  logic                  dma_wr_done
);

    state_t                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] src_q,    src_d;
    logic [ADDR_WIDTH-1:0] dst_q,    dst_d;
    logic [SIZE_WIDTH-1:0] size_q,   size_d;
    logic [SIZE_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [SIZE_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic                  done_q,   done_d;
    logic                  go_accept;
    logic                  buf_full;
    logic                  buf_empty;
    logic [DATA_WIDTH-1:0] buf_head;
    logic                  unused_rd_done;

    // Completion is judged on the write side only.
    assign unused_rd_done = dma_rd_done;

    assign go_accept = (state_q == ST_IDLE) && go;

    // Channel enables are confined to RUN so nothing moves during START or
    // after an abort, regardless of the latched counters.
    assign dma_rd_en = (state_q == ST_RUN) && !dma_empty && !buf_full
                       && (rd_cnt_q < size_q);
    assign dma_wr_en = (state_q == ST_RUN) && !buf_empty && !dma_full;

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        size_d   = size_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        done_d   = done_q;

        if (dma_rd_en) begin
            rd_cnt_d = rd_cnt_q + SIZE_WIDTH'(1);
        end
        if (dma_wr_en) begin
            wr_cnt_d = wr_cnt_q + SIZE_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    src_d    = src_addr;
                    dst_d    = dst_addr;
                    size_d   = size;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    done_d   = 1'b0;
                    state_d  = (size == '0) ? ST_ZERO : ST_START;
                end
            end
            ST_ZERO: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (wr_cnt_q == size_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dma_wr_done) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            size_q   <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            size_q   <= size_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            done_q   <= done_d;
        end
    end

    dma_xfer_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .flush_i (go_accept),
        .push_i  (dma_rd_en),
        .data_i  (dma_rd_data),
        .pop_i   (dma_wr_en),
        .data_o  (buf_head),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

`ifdef DMA_XFER_XFORM_EN
    logic [DATA_WIDTH-1:0] key_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= '0;
        end else if (go_accept) begin
            key_q <= xform_key;
        end
    end

    // Masked while empty so the bus reads zero whenever no line is offered.
    assign dma_wr_data  = buf_empty ? '0 : (buf_head ^ key_q);
    assign xform_active = busy;
`else
    assign dma_wr_data  = buf_empty ? '0 : buf_head;
`endif

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign lines_done  = wr_cnt_q;
    assign dma_rd_addr = src_q;
    assign dma_wr_addr = dst_q;
    assign dma_rd_size = size_q;
    assign dma_wr_size = size_q;
    assign dma_rd_go   = (state_q == ST_START);
    assign dma_wr_go   = (state_q == ST_START);

endmodule
`default_nettype wire

// File: tb/tb_dma_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_xfer_ctrl
// Purpose  : Self-checking bench for dma_xfer_ctrl. A transaction-level model
//            tracks lines popped/pushed and buffer occupancy; write data is
//            checked against the line index sequence generated by the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_xfer_ctrl;

    localparam int AW    = 64;
    localparam int SW    = 17;
    localparam int DW    = 512;
    localparam int DEPTH = 16;

    typedef logic [DW-1:0] wide_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic [AW-1:0] src_addr, dst_addr;
    logic [SW-1:0] size;
    logic          done, busy;
    logic [SW-1:0] lines_done;
    logic [AW-1:0] dma_rd_addr, dma_wr_addr;
    logic [SW-1:0] dma_rd_size, dma_wr_size;
    logic          dma_rd_go, dma_wr_go;
    logic          dma_empty;
    wide_t         dma_rd_data;
    logic          dma_rd_en;
    logic          dma_rd_done;
    logic          dma_full;
    wide_t         dma_wr_data;
    logic          dma_wr_en;
    logic          dma_wr_done;
`ifdef DMA_XFER_XFORM_EN
    wide_t         xform_key;
    logic          xform_active;
`endif

    always #5 clk = ~clk;

    dma_xfer_ctrl #(
        .ADDR_WIDTH (AW),
        .SIZE_WIDTH (SW),
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .size         (size),
        .done         (done),
        .busy         (busy),
        .lines_done   (lines_done),
        .dma_rd_addr  (dma_rd_addr),
        .dma_wr_addr  (dma_wr_addr),
        .dma_rd_size  (dma_rd_size),
        .dma_wr_size  (dma_wr_size),
        .dma_rd_go    (dma_rd_go),
        .dma_wr_go    (dma_wr_go),
        .dma_empty    (dma_empty),
        .dma_rd_data  (dma_rd_data),
        .dma_rd_en    (dma_rd_en),
        .dma_rd_done  (dma_rd_done),
        .dma_full     (dma_full),
        .dma_wr_data  (dma_wr_data),
        .dma_wr_en    (dma_wr_en),
`ifdef DMA_XFER_XFORM_EN
        .xform_key    (xform_key),
        .xform_active (xform_active),
`endif
        .dma_wr_done  (dma_wr_done)
    );

    int errors = 0;
    int checks = 0;

    // Line k of the current transfer tagged by cur_tag.
    function automatic wide_t gen(input int t, input int k);
        wide_t v;
        for (int i = 0; i < DW / 32; i++) begin
            v[i*32 +: 32] = {t[15:0], k[15:0]} ^ (32'(i) * 32'h9E37_79B1);
        end
        return v;
    endfunction

    int cur_tag = 0;
    int src_idx = 0;
    assign dma_rd_data = gen(cur_tag, src_idx);

    // Transaction-level model.
    localparam int P_IDLE = 0, P_ZERO = 1, P_START = 2, P_RUN = 3, P_DRAIN = 4;
    int            ph;
    logic [AW-1:0] m_src, m_dst;
    int            m_size;
    bit            m_done;
    int            rd_pops, wr_push;
    bit            pop_seen, restart_seen;
    int            n_rd = 0, n_wr = 0, n_rgo = 0, n_wgo = 0, n_busy = 0;

    task automatic chk(input string name, input wide_t act, input wide_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        ph      = P_IDLE;
        m_src   = '0;
        m_dst   = '0;
        m_size  = 0;
        m_done  = 1'b0;
        rd_pops = 0;
        wr_push = 0;
    endtask

    // Compare outputs for this cycle, then advance the model across the edge.
    task automatic model_step();
        bit e_rd, e_wr;
        int occ;
        occ  = rd_pops - wr_push;
        e_rd = (ph == P_RUN) && !dma_empty && (occ < DEPTH) && (rd_pops < m_size);
        e_wr = (ph == P_RUN) && (occ > 0) && !dma_full;
        chk("busy",       wide_t'(busy),        wide_t'(ph != P_IDLE));
        chk("done",       wide_t'(done),        wide_t'(m_done));
        chk("lines_done", wide_t'(lines_done),  wide_t'(wr_push));
        chk("rd_go",      wide_t'(dma_rd_go),   wide_t'(ph == P_START));
        chk("wr_go",      wide_t'(dma_wr_go),   wide_t'(ph == P_START));
        chk("rd_en",      wide_t'(dma_rd_en),   wide_t'(e_rd));
        chk("wr_en",      wide_t'(dma_wr_en),   wide_t'(e_wr));
        chk("rd_addr",    wide_t'(dma_rd_addr), wide_t'(m_src));
        chk("wr_addr",    wide_t'(dma_wr_addr), wide_t'(m_dst));
        chk("rd_size",    wide_t'(dma_rd_size), wide_t'(m_size));
        chk("wr_size",    wide_t'(dma_wr_size), wide_t'(m_size));
`ifdef DMA_XFER_XFORM_EN
        chk("xform_active", wide_t'(xform_active), wide_t'(ph != P_IDLE));
`endif
        if (dma_wr_en && e_wr) begin
            chk("wr_data", dma_wr_data, gen(cur_tag, wr_push));
        end
        n_rd   += int'(dma_rd_en);
        n_wr   += int'(dma_wr_en);
        n_rgo  += int'(dma_rd_go);
        n_wgo  += int'(dma_wr_go);
        n_busy += int'(busy);
        pop_seen     = dma_rd_en;
        restart_seen = rst;
        if (rst) begin
            model_reset();
        end else begin
            case (ph)
                P_IDLE: if (go) begin
                    m_src        = src_addr;
                    m_dst        = dst_addr;
                    m_size       = int'(size);
                    m_done       = 1'b0;
                    rd_pops      = 0;
                    wr_push      = 0;
                    restart_seen = 1'b1;
                    ph           = (size == '0) ? P_ZERO : P_START;
                end
                P_ZERO: begin
                    m_done = 1'b1;
                    ph     = P_IDLE;
                end
                P_START: ph = P_RUN;
                P_RUN: begin
                    if (wr_push == m_size) ph = P_DRAIN;
                    if (e_rd) rd_pops++;
                    if (e_wr) wr_push++;
                end
                P_DRAIN: if (dma_wr_done) begin
                    m_done = 1'b1;
                    ph     = P_IDLE;
                end
                default: ph = P_IDLE;
            endcase
        end
    endtask

    // One clock: check at the falling edge, inputs change just after rising.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        if (restart_seen)  src_idx = 0;
        else if (pop_seen) src_idx = src_idx + 1;
    endtask

    task automatic start(input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input int n, input int t);
        cur_tag  = t;
        src_addr = s;
        dst_addr = d;
        size     = SW'(n);
        go       = 1'b1;
        tick();
        go       = 1'b0;
    endtask

    task automatic wait_lines(input int n, input int budget);
        int k = 0;
        while (int'(lines_done) != n && k < budget) begin
            tick();
            k++;
        end
        if (int'(lines_done) != n) chk("lines_timeout", wide_t'(lines_done), wide_t'(n));
    endtask

    task automatic finish_xfer(input int budget);
        int k = 0;
        dma_wr_done = 1'b1;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        if (!done) chk("done_timeout", wide_t'(done), wide_t'(1));
        dma_wr_done = 1'b0;
    endtask

    int b_rd, b_wr, b_rgo, b_wgo, b_busy;
    task automatic snap();
        b_rd = n_rd; b_wr = n_wr; b_rgo = n_rgo; b_wgo = n_wgo; b_busy = n_busy;
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; src_addr = '0; dst_addr = '0; size = '0;
        dma_empty = 1'b0; dma_full = 1'b0; dma_rd_done = 1'b0; dma_wr_done = 1'b0;
`ifdef DMA_XFER_XFORM_EN
        xform_key = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_busy",  wide_t'(busy),       wide_t'(0));
        chk("reset_done",  wide_t'(done),       wide_t'(0));
        chk("reset_lines", wide_t'(lines_done), wide_t'(0));

        // Basic 4-line copy.
        snap();
        start(64'h1000, 64'h2000, 4, 1);
        wait_lines(4, 100);
        finish_xfer(50);
        chk("t1_lines", wide_t'(lines_done), wide_t'(4));
        chk("t1_done",  wide_t'(done),       wide_t'(1));
        chk("t1_rd_en", wide_t'(n_rd - b_rd),   wide_t'(4));
        chk("t1_wr_en", wide_t'(n_wr - b_wr),   wide_t'(4));
        chk("t1_rdgo",  wide_t'(n_rgo - b_rgo), wide_t'(1));
        chk("t1_wrgo",  wide_t'(n_wgo - b_wgo), wide_t'(1));
        repeat (2) tick();

        // Zero-length transfer.
        snap();
        start(64'h3000, 64'h4000, 0, 2);
        tick();
        chk("t2_done", wide_t'(done), wide_t'(1));
        repeat (3) tick();
        chk("t2_rdgo", wide_t'(n_rgo - b_rgo),   wide_t'(0));
        chk("t2_busy", wide_t'(n_busy - b_busy), wide_t'(1));

        // Write side stalled: buffer fills to depth and holds.
        snap();
        dma_full = 1'b1;
        start(64'h5000, 64'h6000, 32, 3);
        repeat (40) tick();
        chk("t3_rd_held", wide_t'(n_rd - b_rd), wide_t'(16));
        chk("t3_wr_held", wide_t'(n_wr - b_wr), wide_t'(0));
        dma_full = 1'b0;
        wait_lines(32, 200);
        finish_xfer(50);
        chk("t3_lines", wide_t'(lines_done), wide_t'(32));

        // Random back-pressure on both channels.
        snap();
        start(64'h7000, 64'h8000, 100, 4);
        for (int k = 0; k < 3000 && int'(lines_done) != 100; k++) begin
            dma_empty = ($urandom_range(0, 2) == 0);
            dma_full  = ($urandom_range(0, 2) == 0);
            tick();
        end
        dma_empty = 1'b0;
        dma_full  = 1'b0;
        wait_lines(100, 10);
        finish_xfer(50);
        chk("t4_wr_en", wide_t'(n_wr - b_wr), wide_t'(100));
        chk("t4_rd_en", wide_t'(n_rd - b_rd), wide_t'(100));

        // Second go while busy is ignored.
        snap();
        dma_full = 1'b1;
        start(64'hA000, 64'hB000, 8, 5);
        repeat (4) tick();
        src_addr = 64'hDEAD; dst_addr = 64'hBEEF; size = SW'(3); go = 1'b1;
        tick();
        go       = 1'b0;
        dma_full = 1'b0;
        wait_lines(8, 100);
        finish_xfer(50);
        chk("t5_lines",   wide_t'(lines_done),  wide_t'(8));
        chk("t5_rd_addr", wide_t'(dma_rd_addr), wide_t'(64'hA000));
        chk("t5_wr_addr", wide_t'(dma_wr_addr), wide_t'(64'hB000));
        chk("t5_wr_en",   wide_t'(n_wr - b_wr), wide_t'(8));

        // Reset mid-transfer, then a clean 2-line transfer.
        start(64'hC000, 64'hD000, 10, 6);
        wait_lines(3, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy",    wide_t'(busy),        wide_t'(0));
        chk("t6_done",    wide_t'(done),        wide_t'(0));
        chk("t6_lines",   wide_t'(lines_done),  wide_t'(0));
        chk("t6_rd_en",   wide_t'(dma_rd_en),   wide_t'(0));
        chk("t6_wr_en",   wide_t'(dma_wr_en),   wide_t'(0));
        chk("t6_wr_data", dma_wr_data,          wide_t'(0));
        chk("t6_rd_addr", wide_t'(dma_rd_addr), wide_t'(0));
        repeat (3) tick();
        start(64'hE000, 64'hF000, 2, 7);
        wait_lines(2, 100);
        finish_xfer(50);
        chk("t6_new_lines", wide_t'(lines_done), wide_t'(2));
        chk("t6_new_done",  wide_t'(done),       wide_t'(1));
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_xfer_ctrl.md
Name: dma_xfer_ctrl

Overview:
- Parametrised DMA transfer sequencer between the MMIO memory map and the DMA read/write channels.
- Copies `size` cache lines from a source virtual address to a destination virtual address through an internal elastic buffer.
- Optionally transforms data in flight.
- Reports a sticky done and a transferred-line count, replacing ad-hoc go/done glue in AFUs.

Parameters:
- ADDR_WIDTH, 64, virtual byte address width.
- SIZE_WIDTH, 17, transfer size width in cache lines.
- DATA_WIDTH, 512, cache line width in bits.
- BUF_DEPTH, 16, internal buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- go  in  1  start pulse from memory map
- src_addr  in  ADDR_WIDTH  source virtual byte address
- dst_addr  in  ADDR_WIDTH  destination virtual byte address
- size  in  SIZE_WIDTH  lines to transfer
- done  out  1  sticky completion flag
- busy  out  1  transfer in progress
- lines_done  out  SIZE_WIDTH  lines written so far
- dma_rd_addr / dma_wr_addr  out  ADDR_WIDTH  latched addresses
- dma_rd_size / dma_wr_size  out  SIZE_WIDTH  latched size
- dma_rd_go / dma_wr_go  out  1  one-cycle channel start
- dma_empty  in  1  read data unavailable
- dma_rd_data  in  DATA_WIDTH  read data
- dma_rd_en  out  1  pop read data
- dma_rd_done  in  1  read channel complete
- dma_full  in  1  write channel cannot accept
- dma_wr_data  out  DATA_WIDTH  write data
- dma_wr_en  out  1  push write data
- dma_wr_done  in  1  write channel complete

Behaviour:
- Single clock domain. Reset is synchronous and active high.
- Reset values: all outputs 0, state IDLE, buffer empty, counters 0.
- States:
  - IDLE: go=1 latches src/dst/size, clears done and counters. Next state is ZERO if size==0, else START.
  - ZERO: done<=1, go to IDLE. No DMA go is issued.
  - START: dma_rd_go=dma_wr_go=1 for exactly one cycle, then RUN.
  - RUN: see read and write side below. When wr_cnt==size, go to DRAIN.
  - DRAIN: wait for dma_wr_done=1, then done<=1 and go to IDLE.
- busy=1 in every state except IDLE.
- Read side: dma_rd_en = !dma_empty && !buf_full && rd_cnt<size. Each pop pushes dma_rd_data into the buffer and increments rd_cnt.
- Write side: dma_wr_en = !buf_empty && !dma_full. dma_wr_data is the buffer head (show-ahead). Each push pops the buffer and increments wr_cnt.
- lines_done = wr_cnt.
- Latency: a line popped at cycle t appears on dma_wr_en no earlier than t+1.
- Buffer may push and pop in the same cycle when it is not empty; the count is unchanged.
- Buffer full: dma_rd_en is held low and no data is lost. Buffer empty: dma_wr_en is held low.
- go while busy is ignored; latched values are unchanged.
- done stays 1 until the next accepted go or reset.
- dma_rd_done is not used for completion. Completion is wr_cnt==size plus dma_wr_done.
- Counters are SIZE_WIDTH bits. Maximum size 2^SIZE_WIDTH-1 never wraps.
- rst mid-transfer: abort immediately, flush the buffer, return to IDLE with done=0. No further DMA enables are asserted.

Optional Feature:
- Macro DMA_XFER_XFORM_EN.
- When defined:
  - Adds input xform_key [DATA_WIDTH-1:0], latched on accepted go.
  - dma_wr_data = buffer head XOR latched key.
  - Adds output xform_active, 1 while busy.
- When undefined: ports absent, data passes unmodified, no extra logic.

Decomposition:
- Package dma_xfer_pkg:
  - state enum (IDLE, ZERO, START, RUN, DRAIN)
  - CL_BYTES=64 constant
  - count/address typedef helpers
- Sub-module dma_xfer_buf:
  - synchronous show-ahead FIFO with parameters DATA_WIDTH and BUF_DEPTH
  - full/empty flags
  - synchronous flush input

Test Plan:
- size=4, src=0x1000, dst=0x2000, dma_empty=0 and dma_full=0 always -> one-cycle rd_go/wr_go; 4 rd_en, 4 wr_en; data order preserved; done=1 after dma_wr_done; lines_done=4.
- size=0 -> no rd_go/wr_go; done=1 two cycles after go; busy pulses for one cycle.
- size=32, BUF_DEPTH=16, dma_full=1 for 40 cycles -> exactly 16 rd_en then rd_en low; after dma_full=0, all 32 lines written in order.
- Random dma_empty/dma_full toggling, size=100 -> wr_en count 100; no rd_en when buffer full; no wr_en when buffer empty.
- Second go asserted mid-transfer of size=8 -> ignored; exactly 8 lines transferred; addresses unchanged.
- rst asserted after 3 of 10 lines written -> next cycle all outputs 0 and buffer empty; new go with size=2 completes normally with lines_done=2.
